// File: rtl/riscv_fetch_unit.sv
// Single-outstanding instruction fetch stage: REQ -> WAIT -> HOLD, with redirect and response drop.
// Optional macro RISCV_FETCH_MISALIGN_EN adds a sticky misaligned-target fault and a FAULT state.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
`ifdef RISCV_FETCH_MISALIGN_EN
  ,
  output logic        fetch_fault,
  output logic [31:0] fault_addr
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
`ifdef RISCV_FETCH_MISALIGN_EN
    ,
    S_FAULT = 2'd3
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        run_q, run_d;
`ifdef RISCV_FETCH_MISALIGN_EN
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;
`endif

  logic        req_fire;
  logic [31:0] redirect_pc;

  // run_q keeps the request line low while in reset and through the first edge after it.
  assign imem_req_valid = run_q && (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign if_valid       = (state_q == S_HOLD);
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign redirect_pc    = redirect_target & 32'hFFFF_FFFC;
`ifdef RISCV_FETCH_MISALIGN_EN
  assign fetch_fault    = fault_q;
  assign fault_addr     = fault_addr_q;
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through this block infers a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    run_d      = 1'b1;
`ifdef RISCV_FETCH_MISALIGN_EN
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
`endif

    case (state_q)
      S_REQ: begin
        if (req_fire) state_d = S_WAIT;
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (req_fire) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          drop_d = 1'b0;
          if (drop_q || redirect_valid) begin
            state_d = S_REQ;
          end else begin
            if_pc_d    = pc_q;
            if_instr_d = imem_rsp_data;
            pc_d       = pc_q + 32'd4;
            state_d    = S_HOLD;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
        if (redirect_valid) pc_d = redirect_pc;
      end
      S_HOLD: begin
        // A redirect leaves HOLD regardless of if_ready; a coincident handshake still counts.
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (if_ready) begin
          state_d = S_REQ;
        end
      end
`ifdef RISCV_FETCH_MISALIGN_EN
      S_FAULT: begin
        state_d = S_FAULT;
      end
`endif
      default: state_d = S_REQ;
    endcase

`ifdef RISCV_FETCH_MISALIGN_EN
    if (redirect_valid && (redirect_target[1:0] != 2'b00) && (state_q != S_FAULT)) begin
      fault_d      = 1'b1;
      fault_addr_d = redirect_target;
      drop_d       = 1'b0;
      pc_d         = pc_q;
      state_d      = S_FAULT;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_pc_q    <= 32'h0000_0000;
      if_instr_q <= NOP;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      run_q      <= run_d;
    end
  end

`ifdef RISCV_FETCH_MISALIGN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0000_0000;
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: transaction-level fetch model, latency-configurable memory, directed redirects.
// Honours RISCV_FETCH_MISALIGN_EN when defined.
module tb_riscv_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef RISCV_FETCH_MISALIGN_EN
  logic        fetch_fault;
  logic [31:0] fault_addr;
`endif

  always #5 clk = ~clk;

  riscv_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr)
`ifdef RISCV_FETCH_MISALIGN_EN
    ,
    .fetch_fault     (fetch_fault),
    .fault_addr      (fault_addr)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus knobs applied on every tick.
  logic        rv_set = 1'b0;
  logic [31:0] rt_set = '0;
  logic        rdy_set = 1'b1;
  logic        mrdy_set = 1'b1;
  int          lat = 1;

  // Memory responder.
  logic        pending = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;

  // Transaction-level model: next fetch address, outstanding request, pending deliveries.
  logic [31:0] m_pc = RPC;
  logic        m_out = 1'b0;
  logic        m_drop = 1'b0;
  logic [31:0] m_addr = '0;
  logic        m_fault = 1'b0;
  logic [31:0] m_faddr = '0;
  logic [31:0] deliv_q[$];
  logic [31:0] req_log[$];
  logic [31:0] if_log[$];
  int          if_cyc[$];
  int          cyc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic        rsp_now, redir, req_fire, if_fire;
    logic [31:0] tgt, v;
    @(negedge clk);
    cyc++;
    redir = rv_set;
    tgt   = rt_set;
    redirect_valid  = rv_set;
    redirect_target = rt_set;
    if_ready        = rdy_set;
    imem_req_ready  = mrdy_set;
    rsp_now = 1'b0;
    if (pending && cnt == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(paddr);
      rsp_now = 1'b1;
      pending = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
      if (pending) cnt--;
    end

    check("req_valid", {31'b0, imem_req_valid}, {31'b0, !m_out && deliv_q.size() == 0 && !m_fault});
    check("if_valid", {31'b0, if_valid}, {31'b0, deliv_q.size() != 0});
    if (if_valid && deliv_q.size() != 0) begin
      check("if_pc", if_pc, deliv_q[0]);
      check("if_instr", if_instr, mem_word(deliv_q[0]));
    end
`ifdef RISCV_FETCH_MISALIGN_EN
    check("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    check("fault_addr", fault_addr, m_faddr);
`endif

    req_fire = imem_req_valid && imem_req_ready;
    if_fire  = if_valid && if_ready;
    if (if_valid && deliv_q.size() != 0 && (if_fire || redir)) begin
      v = deliv_q.pop_front();
      if (if_fire) begin
        if_log.push_back(v);
        if_cyc.push_back(cyc);
      end
    end
    if (rsp_now && m_out) begin
      m_out = 1'b0;
      if (!m_drop && !redir) begin
        deliv_q.push_back(m_addr);
        m_pc = m_addr + 32'd4;
      end
      m_drop = 1'b0;
    end
    if (req_fire) begin
      check("req_addr", imem_req_addr, m_pc);
      req_log.push_back(imem_req_addr);
      m_out  = 1'b1;
      m_addr = m_pc;
      m_drop = 1'b0;
      pending = 1'b1;
      paddr   = imem_req_addr;
      cnt     = lat - 1;
    end
    if (redir) begin
      if (m_out) m_drop = 1'b1;
      m_pc = tgt & 32'hFFFF_FFFC;
`ifdef RISCV_FETCH_MISALIGN_EN
      if (tgt[1:0] != 2'b00 && !m_fault) begin
        m_fault = 1'b1;
        m_faddr = tgt;
        m_out   = 1'b0;
        deliv_q.delete();
      end
`endif
    end
  endtask

  function automatic bit done(input int kind, input int n);
    case (kind)
      0: return if_log.size() >= n;
      1: return m_out;
      2: return deliv_q.size() != 0;
      3: return req_log.size() >= n;
      4: return !m_out && deliv_q.size() == 0 && m_pc == 32'(n);
      5: return !m_out && deliv_q.size() == 0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic wait_for(input int kind, input int n, input string name);
    int b = 0;
    while (!done(kind, n) && b < 200) begin
      tick();
      b++;
    end
    if (!done(kind, n)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout %s: condition not reached in 200 cycles", name);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    if_ready = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    rv_set = 1'b0;
    pending = 1'b0;
    m_pc = RPC;
    m_out = 1'b0;
    m_drop = 1'b0;
    m_fault = 1'b0;
    m_faddr = '0;
    deliv_q.delete();
    req_log.delete();
    if_log.delete();
    if_cyc.delete();
    #1;
    check("rst req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst if_valid", {31'b0, if_valid}, 32'd0);
    check("rst if_pc", if_pc, 32'h0);
    check("rst if_instr", if_instr, 32'h0000_0013);
    check("rst req_addr", imem_req_addr, RPC);
`ifdef RISCV_FETCH_MISALIGN_EN
    check("rst fetch_fault", {31'b0, fetch_fault}, 32'd0);
    check("rst fault_addr", fault_addr, 32'h0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    #1;
    check("mem_word pin", mem_word(32'h100), 32'hFEFF_0100);

    // Zero-wait streaming from RESET_PC and throughput.
    lat = 1; rdy_set = 1'b1; mrdy_set = 1'b1;
    do_reset();
    wait_for(0, 3, "three fetches");
    if (if_log.size() >= 3) begin
      check("seq req0", req_log[0], 32'h100);
      check("seq req1", req_log[1], 32'h104);
      check("seq req2", req_log[2], 32'h108);
      check("seq pc0", if_log[0], 32'h100);
      check("seq pc1", if_log[1], 32'h104);
      check("seq pc2", if_log[2], 32'h108);
      check("throughput01", 32'(if_cyc[1] - if_cyc[0]), 32'd3);
      check("throughput12", 32'(if_cyc[2] - if_cyc[1]), 32'd3);
    end

    // Decode stalls for 5 cycles in HOLD.
    rdy_set = 1'b0;
    wait_for(2, 0, "reach hold");
    repeat (5) tick();
    rdy_set = 1'b1;
    wait_for(0, if_log.size() + 1, "stall release");

    // Redirect in WAIT, response 3 cycles later is dropped.
    lat = 4;
    wait_for(1, 0, "accept before wait redirect");
    k = req_log.size();
    rv_set = 1'b1; rt_set = 32'h200;
    tick();
    rv_set = 1'b0;
    wait_for(0, if_log.size() + 1, "fetch after wait redirect");
    check("wait redirect req", req_log[k], 32'h200);
    check("wait redirect if_pc", if_log[if_log.size() - 1], 32'h200);

    // Two redirects before the response: last target wins.
    wait_for(1, 0, "accept before double redirect");
    rv_set = 1'b1; rt_set = 32'h500;
    tick();
    rt_set = 32'h600;
    tick();
    rv_set = 1'b0;
    wait_for(0, if_log.size() + 1, "fetch after double redirect");
    check("double redirect if_pc", if_log[if_log.size() - 1], 32'h600);

    // Redirect in HOLD without and with a coincident handshake.
    lat = 1;
    rdy_set = 1'b0;
    wait_for(2, 0, "hold for cancel");
    k = if_log.size();
    rv_set = 1'b1; rt_set = 32'h700;
    tick();
    rv_set = 1'b0;
    check("hold cancel not taken", 32'(if_log.size()), 32'(k));
    rdy_set = 1'b1;
    wait_for(0, k + 1, "fetch after hold redirect");
    check("hold redirect if_pc", if_log[if_log.size() - 1], 32'h700);
    rdy_set = 1'b0;
    wait_for(2, 0, "hold for taken redirect");
    rdy_set = 1'b1;
    rv_set = 1'b1; rt_set = 32'h800;
    k = if_log.size();
    tick();
    rv_set = 1'b0;
    check("hold redirect taken pc", if_log[if_log.size() - 1], 32'h704);
    wait_for(0, k + 2, "fetch after taken hold redirect");
    check("taken hold redirect if_pc", if_log[if_log.size() - 1], 32'h800);

    // Redirect coincident with acceptance of 0x104.
    do_reset();
    wait_for(4, 32'h104, "idle at 0x104");
    k = req_log.size();
    rv_set = 1'b1; rt_set = 32'h300;
    tick();
    rv_set = 1'b0;
    check("accept-redirect req", req_log[k], 32'h104);
    wait_for(0, if_log.size() + 1, "fetch after accept redirect");
    check("accept-redirect next req", req_log[k + 1], 32'h300);
    check("accept-redirect if_pc", if_log[if_log.size() - 1], 32'h300);

    // Misaligned redirect in REQ without acceptance.
    wait_for(5, 0, "idle before misaligned");
    k = req_log.size();
    mrdy_set = 1'b0;
    rv_set = 1'b1; rt_set = 32'h402;
    tick();
    rv_set = 1'b0;
    mrdy_set = 1'b1;
`ifdef RISCV_FETCH_MISALIGN_EN
    repeat (10) tick();
    check("fault flag", {31'b0, fetch_fault}, 32'd1);
    check("fault addr", fault_addr, 32'h402);
    check("no req in fault", 32'(req_log.size()), 32'(k));
`else
    wait_for(0, if_log.size() + 1, "fetch after misaligned");
    check("masked req", req_log[k], 32'h400);
    check("masked if_pc", if_log[if_log.size() - 1], 32'h400);
`endif

    // Asynchronous reset while a response is outstanding.
    do_reset();
    lat = 5;
    wait_for(1, 0, "accept before reset");
    tick();
    #2;
    do_reset();
    lat = 1;
    wait_for(0, 2, "restart after reset");
    check("restart req", req_log[0], RPC);
    check("restart if_pc", if_log[0], RPC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
